// File: rtl/pwls_spi_pkg.sv
// Shared types and frame layout for the SPI-to-register-bus bridge.
// The frame layout assumes the default 13-bit data and 6-bit address widths.
package pwls_spi_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    WRITE     = 2'd2,
    READ_WAIT = 2'd3
  } state_e;

  localparam int RW_BIT         = 23;
  localparam int ADDR_MSB       = 18;
  localparam int ADDR_LSB       = 13;
  localparam int DATA_MSB       = 12;
  localparam int FRAME_BITS     = 24;
  localparam int ADDR_DONE_BITS = 11;

  localparam logic [1:0] STROBE_ON  = 2'b10;
  localparam logic [1:0] STROBE_OFF = 2'b11;

  // Reply word shifted out on MISO during the frame after a read.
  function automatic logic [FRAME_BITS-1:0] miso_frame(input logic valid,
                                                       input logic err,
                                                       input logic [DATA_MSB:0] data);
    return {valid, err, 9'b0_0000_0000, data};
  endfunction

endpackage

// File: rtl/pwls_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with single-cycle rise/fall pulses
// derived from the last two synchronized samples.
module pwls_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/pwls_spi_reg_bridge.sv
// SPI mode-0 slave that decodes 24-bit frames into register bus writes and reads;
// read results are returned on MISO during the following frame.
module pwls_spi_reg_bridge
  import pwls_spi_pkg::*;
#(
  parameter int BITS_E       = 13,
  parameter int ADDR_BITS    = 6,
  parameter int READ_TIMEOUT = 15,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_sclk,
  input  logic                 spi_cs_n,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 spi_miso_oe,
  output logic [ADDR_BITS-1:0] address,
  output logic [BITS_E-1:0]    data_in,
  output logic [1:0]           data_write_n,
  output logic [1:0]           data_read_n,
  input  logic [BITS_E-1:0]    data_out,
  input  logic                 data_ready
);

  localparam int                TMR_W    = $clog2(READ_TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(READ_TIMEOUT - 1);
  localparam int                DONE_OFS = FRAME_BITS - ADDR_DONE_BITS;
  localparam logic [4:0]        CNT_FULL = 5'(FRAME_BITS);
  localparam logic [4:0]        CNT_ADDR = 5'(ADDR_DONE_BITS);

  logic sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  state_e                 state_q;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [TMR_W-1:0]       tmr_q;
  logic [ADDR_BITS-1:0]   address_q;
  logic [BITS_E-1:0]      data_in_q, rdata_q;
  logic [1:0]             write_n_q, read_n_q;
  logic                   rd_valid_q, rd_err_q;
  logic [FRAME_BITS-1:0]  miso_sr_q;
  logic                   miso_q, sel_q;
  logic                   take_bit_s, cs_high_s;

  pwls_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_sclk),
    .rise_o (sclk_rise_s),
    .fall_o (sclk_fall_s)
  );

  pwls_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_cs_n),
    .rise_o (cs_rise_s),
    .fall_o (cs_fall_s)
  );

  // Plain synchronizer for MOSI, aligned in latency with the sclk edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_high_s = ~sel_q;

  // Next shift-register contents and bit count for an incoming sclk rise.
  always_comb begin
    shift_d    = {shift_q[FRAME_BITS-2:0], mosi_s};
    bit_cnt_d  = bit_cnt_q + 5'd1;
    take_bit_s = 1'b0;
    if (sclk_rise_s && (state_q != IDLE) && (bit_cnt_q < CNT_FULL)) begin
      take_bit_s = 1'b1;
    end else begin
      take_bit_s = 1'b0;
    end
  end

  // Frame decode and register-bus strobe sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= 5'd0;
      tmr_q      <= '0;
      address_q  <= '0;
      data_in_q  <= '0;
      write_n_q  <= STROBE_OFF;
      read_n_q   <= STROBE_OFF;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      if (take_bit_s) begin
        shift_q   <= shift_d;
        bit_cnt_q <= bit_cnt_d;
      end
      case (state_q)
        IDLE: begin
          if (cs_fall_s) begin
            shift_q   <= '0;
            bit_cnt_q <= 5'd0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_high_s) begin
            state_q <= IDLE;
          end else if (take_bit_s && (bit_cnt_d == CNT_ADDR) && shift_d[RW_BIT-DONE_OFS]) begin
            address_q  <= shift_d[ADDR_MSB-DONE_OFS:ADDR_LSB-DONE_OFS];
            read_n_q   <= STROBE_ON;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            tmr_q      <= '0;
            state_q    <= READ_WAIT;
          end else if (take_bit_s && (bit_cnt_d == CNT_FULL) && !shift_d[RW_BIT]) begin
            address_q <= shift_d[ADDR_MSB:ADDR_LSB];
            data_in_q <= shift_d[DATA_MSB:0];
            write_n_q <= STROBE_ON;
            state_q   <= WRITE;
          end
        end
        WRITE: begin
          write_n_q <= STROBE_OFF;
          state_q   <= cs_high_s ? IDLE : SHIFT;
        end
        READ_WAIT: begin
          // Data arriving on the final timeout cycle takes priority over the error.
          if (data_ready) begin
            rdata_q    <= data_out;
            rd_valid_q <= 1'b1;
            rd_err_q   <= 1'b0;
            read_n_q   <= STROBE_OFF;
            state_q    <= cs_high_s ? IDLE : SHIFT;
          end else if (tmr_q == TMR_LAST) begin
            rdata_q    <= '1;
            rd_valid_q <= 1'b1;
            rd_err_q   <= 1'b1;
            read_n_q   <= STROBE_OFF;
            state_q    <= cs_high_s ? IDLE : SHIFT;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // MISO reply shifter; sel_q tracks the synchronized chip-select level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_sr_q <= '0;
      miso_q    <= 1'b0;
      sel_q     <= 1'b0;
    end else begin
      if (cs_fall_s) begin
        sel_q     <= 1'b1;
        miso_sr_q <= miso_frame(rd_valid_q, rd_err_q, rdata_q);
        miso_q    <= rd_valid_q;
      end else if (cs_rise_s) begin
        sel_q  <= 1'b0;
        miso_q <= 1'b0;
      end else if (sclk_fall_s && sel_q) begin
        miso_sr_q <= {miso_sr_q[FRAME_BITS-2:0], 1'b0};
        miso_q    <= miso_sr_q[FRAME_BITS-2];
      end
    end
  end

  assign spi_miso     = miso_q;
  assign spi_miso_oe  = sel_q;
  assign address      = address_q;
  assign data_in      = data_in_q;
  assign data_write_n = write_n_q;
  assign data_read_n  = read_n_q;

endmodule
